// File: rtl/pll_dri_master.sv
// pll_dri_master: command-driven master for a PLL dynamic reconfiguration
// interface (DRI). Supports reads and masked writes (read-modify-write);
// an all-ones mask skips the read phase. Every DRI handshake and the optional
// lock wait are bounded by TIMEOUT_CYC cycles, and a timeout is reported
// through RSP_ERR.
// Optional feature: define PLL_DRI_LOCK_WAIT_EN to wait for PLL_LOCK after a
// write before responding. Without the macro PLL_LOCK is ignored.
module pll_dri_master #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        CLK,
  input  logic        ARST_N,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WR,
  input  logic [8:0]  CMD_ADDR,
  input  logic [31:0] CMD_WDATA,
  input  logic [31:0] CMD_MASK,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        BUSY,
  output logic [10:0] DRI_CTRL,
  output logic [32:0] DRI_WDATA,
  input  logic [32:0] DRI_RDATA,
  input  logic        PLL_LOCK
);

  typedef enum logic [2:0] {IDLE, RD, WR, LOCK_WAIT, RSP} state_t;

  // The last count value before the wait limit is reached.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        wr_q;
  logic [8:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mask_q;

  logic ack;
  logic req;
  assign ack = DRI_RDATA[32];
  assign req = DRI_CTRL[10];

`ifndef PLL_DRI_LOCK_WAIT_EN
  logic unused_pll_lock;
  assign unused_pll_lock = PLL_LOCK;
`endif

  // Transaction FSM. All outputs are registered. REQ is released in the
  // cycle after the ack. ADDR and WDATA stay constant while REQ is high.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      CMD_READY <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
      BUSY      <= 1'b0;
      DRI_CTRL  <= '0;
      DRI_WDATA <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (CMD_VALID && CMD_READY) begin
            wr_q      <= CMD_WR;
            addr_q    <= CMD_ADDR;
            wdata_q   <= CMD_WDATA;
            mask_q    <= CMD_MASK;
            CMD_READY <= 1'b0;
            BUSY      <= 1'b1;
            cnt       <= '0;
            if (CMD_WR && (&CMD_MASK)) begin
              state     <= WR;
              DRI_CTRL  <= {1'b1, 1'b1, CMD_ADDR};
              DRI_WDATA <= {1'b0, CMD_WDATA};
            end else begin
              state    <= RD;
              DRI_CTRL <= {1'b1, 1'b0, CMD_ADDR};
            end
          end else begin
            CMD_READY <= 1'b1;
          end
        end

        RD: begin
          if (req && ack) begin
            DRI_CTRL[10] <= 1'b0;
            if (wr_q) begin
              // Merge: unmasked bits keep the current register value.
              state     <= WR;
              cnt       <= '0;
              DRI_WDATA <= {1'b0, (DRI_RDATA[31:0] & ~mask_q) | (wdata_q & mask_q)};
            end else begin
              state     <= RSP;
              RSP_VALID <= 1'b1;
              RSP_RDATA <= DRI_RDATA[31:0];
              RSP_ERR   <= 1'b0;
            end
          end else if (cnt == TMO_LAST) begin
            DRI_CTRL[10] <= 1'b0;
            state        <= RSP;
            RSP_VALID    <= 1'b1;
            RSP_RDATA    <= '0;
            RSP_ERR      <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        WR: begin
          if (!req) begin
            // After a read phase, REQ stays low for one cycle and then
            // the write request is raised with the merged data.
            DRI_CTRL <= {1'b1, 1'b1, addr_q};
          end else if (ack) begin
            DRI_CTRL[10] <= 1'b0;
            RSP_RDATA    <= DRI_WDATA[31:0];
`ifdef PLL_DRI_LOCK_WAIT_EN
            state <= LOCK_WAIT;
            cnt   <= '0;
`else
            state     <= RSP;
            RSP_VALID <= 1'b1;
            RSP_ERR   <= 1'b0;
`endif
          end else if (cnt == TMO_LAST) begin
            DRI_CTRL[10] <= 1'b0;
            state        <= RSP;
            RSP_VALID    <= 1'b1;
            RSP_RDATA    <= '0;
            RSP_ERR      <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

`ifdef PLL_DRI_LOCK_WAIT_EN
        LOCK_WAIT: begin
          // The first cycle here is never accepted, so at least two cycles
          // pass before the response.
          if ((cnt != 16'd0) && PLL_LOCK) begin
            state     <= RSP;
            RSP_VALID <= 1'b1;
            RSP_ERR   <= 1'b0;
          end else if (cnt == TMO_LAST) begin
            state     <= RSP;
            RSP_VALID <= 1'b1;
            RSP_ERR   <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif

        RSP: begin
          RSP_VALID <= 1'b0;
          BUSY      <= 1'b0;
          CMD_READY <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state     <= IDLE;
          RSP_VALID <= 1'b0;
          BUSY      <= 1'b0;
          DRI_CTRL  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/pll_dri_master.md
PLL_DRI_MASTER -- requirements
Module: pll_dri_master

Interface
REQ-001 SHALL provide parameter: TIMEOUT_CYC, 255, maximum wait cycles for a DRI ack or PLL lock (legal 1..65535).
REQ-002 SHALL provide ports:
  CLK  in  1  system clock, same clock connected to the PLL DRI_CLK
  ARST_N  in  1  reset, asynchronous, active-low
  CMD_VALID  in  1  command request
  CMD_READY  out  1  command accept
  CMD_WR  in  1  1 = masked write (read-modify-write), 0 = read
  CMD_ADDR  in  9  PLL DRI register address
  CMD_WDATA  in  32  write data
  CMD_MASK  in  32  1-bits taken from CMD_WDATA; all-ones = plain write
  RSP_VALID  out  1  one-cycle response strobe
  RSP_RDATA  out  32  read data (read: register value; write: value written)
  RSP_ERR  out  1  timeout flag, valid with RSP_VALID
  BUSY  out  1  high in every state except IDLE
  DRI_CTRL  out  11  {REQ, WR, ADDR[8:0]} to PLL DRI
  DRI_WDATA  out  33  {1'b0, data[31:0]} to PLL DRI
  DRI_RDATA  in  33  {ACK, data[31:0]} from PLL DRI
  PLL_LOCK  in  1  PLL lock status

Function
REQ-003 SHALL implement states IDLE, RD, WR, LOCK_WAIT, RSP.
REQ-004 SHALL assert CMD_READY only in IDLE and accept a command on CMD_VALID & CMD_READY, registering CMD_WR/ADDR/WDATA/MASK.
REQ-005 SHALL go IDLE->WR when CMD_WR=1 and CMD_MASK=all-ones; otherwise IDLE->RD.
REQ-006 SHALL in RD drive REQ=1, WR=0 until ACK=1, capturing DRI_RDATA[31:0] in the ACK cycle.
REQ-007 SHALL after RD go to RSP for a read, or to WR for a masked write.
REQ-008 SHALL in WR drive REQ=1, WR=1, data = (rd & ~MASK) | (WDATA & MASK), held stable until ACK=1.
REQ-009 SHALL drop REQ in the cycle following the ACK cycle; ACK while REQ=0 SHALL be ignored.
REQ-010 SHALL pulse RSP_VALID for exactly one cycle in RSP, then return to IDLE.
REQ-011 SHALL give a read with ACK on the first REQ cycle this latency: accept at cycle 0, REQ at cycle 1, RSP_VALID at cycle 2.
REQ-012 SHALL reset a 16-bit wait counter on entry to RD, WR and LOCK_WAIT.
REQ-013 SHALL on the counter reaching TIMEOUT_CYC without ACK: drop REQ, enter RSP with RSP_ERR=1, and return RSP_RDATA=0 for a failed read.
REQ-014 SHALL keep RSP_ERR=0 on every successful transaction.
REQ-015 SHALL hold DRI_CTRL ADDR and DRI_WDATA unchanged while REQ=1.
REQ-016 SHALL drive DRI_WDATA[32] constant 0.

Reset
REQ-017 SHALL on ARST_N=0 immediately force state=IDLE, CMD_READY=0, RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0, BUSY=0, DRI_CTRL=0, DRI_WDATA=0, counter=0.
REQ-018 SHALL abort any transaction when reset arrives mid-operation, with no response issued.
REQ-019 SHALL raise CMD_READY on the first CLK edge after ARST_N deasserts.

Configuration
REQ-020 SHALL, with macro PLL_DRI_LOCK_WAIT_EN defined, enter LOCK_WAIT after a successful WR ack; LOCK_WAIT SHALL wait at least 2 cycles, then until PLL_LOCK=1, then go to RSP, with timeout per REQ-013 setting RSP_ERR=1.
REQ-021 SHALL, without PLL_DRI_LOCK_WAIT_EN, go WR->RSP directly, keep the PLL_LOCK port, and ignore it.

Verification
REQ-022 SHALL cover a read of addr 0x01A where the responder acks after 3 cycles with 0x0000_1234 -> one RSP_VALID, RSP_RDATA=0x0000_1234, RSP_ERR=0.
REQ-023 SHALL cover a masked write of addr 0x010, current value 0xFFFF_0000, WDATA 0x0000_00AB, MASK 0x0000_00FF -> DRI write data 0xFFFF_00AB and exactly one read then one write request.
REQ-024 SHALL cover a plain write with MASK=0xFFFF_FFFF -> no RD phase; first REQ has WR=1.
REQ-025 SHALL cover a responder that never acks with TIMEOUT_CYC=8 -> REQ drops after 8 cycles; RSP_ERR=1, RSP_RDATA=0.
REQ-026 SHALL cover ARST_N asserted while REQ=1 -> DRI_CTRL=0 immediately, no RSP_VALID, CMD_READY=1 one cycle after release.
REQ-027 SHALL cover, with PLL_DRI_LOCK_WAIT_EN, PLL_LOCK low for 20 cycles after the write ack -> RSP_VALID no earlier than the cycle after PLL_LOCK rises, RSP_ERR=0 (TIMEOUT_CYC=255).
